// File: rtl/axi_pkg.sv
// Shared constants and FSM state encoding for the AXI3 memory responder.
package axi_pkg;

  localparam int unsigned ID_W   = 6;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RMEM  = 3'd1,
    ST_RWAIT = 3'd2,
    ST_RDATA = 3'd3,
    ST_WDATA = 3'd4,
    ST_WWAIT = 3'd5,
    ST_WRESP = 3'd6
  } state_e;

endpackage

// File: rtl/axi_slave_mem.sv
// AXI3 slave terminating a 64-bit master port onto a request/ack memory port.
// One transaction at a time, INCR/FIXED bursts of 1..16 beats; beats outside
// the MEMSIZE window (or with a reserved burst type) answer SLVERR without
// touching memory.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter logic [31:0] MEMSIZE   = 32'h0040_0000,
  parameter int unsigned MADDRBITS = 19
) (
  input  logic                 clk,
  input  logic                 axiaresetn,
  input  logic [31:0]          axiawaddr,
  input  logic [ID_W-1:0]      axiawid,
  input  logic [3:0]           axiawlen,
  input  logic [1:0]           axiawburst,
  input  logic                 axiawvalid,
  output logic                 axiawready,
  input  logic [DATA_W-1:0]    axiwdata,
  input  logic [STRB_W-1:0]    axiwstrb,
  input  logic                 axiwlast,
  input  logic                 axiwvalid,
  output logic                 axiwready,
  output logic [ID_W-1:0]      axibid,
  output logic [1:0]           axibresp,
  output logic                 axibvalid,
  input  logic                 axibready,
  input  logic [31:0]          axiaraddr,
  input  logic [ID_W-1:0]      axiarid,
  input  logic [3:0]           axiarlen,
  input  logic [1:0]           axiarburst,
  input  logic                 axiarvalid,
  output logic                 axiarready,
  output logic [DATA_W-1:0]    axirdata,
  output logic [ID_W-1:0]      axirid,
  output logic [1:0]           axirresp,
  output logic                 axirlast,
  output logic                 axirvalid,
  input  logic                 axirready,
  output logic                 memreq,
  output logic                 memwr,
  output logic [MADDRBITS-1:0] memaddr,
  output logic [DATA_W-1:0]    memwdata,
  output logic [STRB_W-1:0]    memwstrb,
  input  logic                 memack,
  input  logic [DATA_W-1:0]    memrdata
);

  state_e                state_q, state_d;
  logic                  lastw_q, lastw_d;
  logic [31:0]           addr_q, addr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [3:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic [3:0]            beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  wdone_q, wdone_d;
  logic                  memreq_q, memreq_d;
  logic                  memwr_q, memwr_d;
  logic [MADDRBITS-1:0]  memaddr_q, memaddr_d;
  logic [DATA_W-1:0]     memwdata_q, memwdata_d;
  logic [STRB_W-1:0]     memwstrb_q, memwstrb_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  bvalid_q, bvalid_d;

  logic                  aw_grant;
  logic                  beat_err;
  logic                  is_last;
  logic [31:0]           next_addr;

  // Arbitration and per-beat decode; readys are gated by reset so they read 0 in reset.
  always_comb begin
    aw_grant   = axiawvalid && (!axiarvalid || !lastw_q);
    beat_err   = (addr_q >= MEMSIZE) || burst_q[1];
    is_last    = (beat_q == len_q);
    next_addr  = (burst_q == BURST_FIXED) ? addr_q : addr_q + 32'd8;
    axiawready = axiaresetn && (state_q == ST_IDLE) && aw_grant;
    axiarready = axiaresetn && (state_q == ST_IDLE) && axiarvalid && !aw_grant;
    axiwready  = axiaresetn && (state_q == ST_WDATA);
  end

  assign memreq    = memreq_q;
  assign memwr     = memwr_q;
  assign memaddr   = memaddr_q;
  assign memwdata  = memwdata_q;
  assign memwstrb  = memwstrb_q;
  assign axirdata  = rdata_q;
  assign axirid    = id_q;
  assign axirresp  = rresp_q;
  assign axirlast  = rlast_q;
  assign axirvalid = rvalid_q;
  assign axibid    = id_q;
  assign axibresp  = bresp_q;
  assign axibvalid = bvalid_q;

  // Next-state and registered-output decode; memreq is a registered pulse, so it
  // is visible during the first cycle of RWAIT/WWAIT.
  always_comb begin
    state_d    = state_q;
    lastw_d    = lastw_q;
    addr_d     = addr_q;
    id_d       = id_q;
    len_d      = len_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    err_d      = err_q;
    wdone_d    = wdone_q;
    memreq_d   = 1'b0;
    memwr_d    = memwr_q;
    memaddr_d  = memaddr_q;
    memwdata_d = memwdata_q;
    memwstrb_d = memwstrb_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    rvalid_d   = rvalid_q;
    bresp_d    = bresp_q;
    bvalid_d   = bvalid_q;

    case (state_q)
      ST_IDLE: begin
        if (aw_grant) begin
          addr_d  = axiawaddr;
          id_d    = axiawid;
          len_d   = axiawlen;
          burst_d = axiawburst;
          beat_d  = '0;
          err_d   = 1'b0;
          lastw_d = 1'b1;
          state_d = ST_WDATA;
        end else if (axiarvalid) begin
          addr_d  = axiaraddr;
          id_d    = axiarid;
          len_d   = axiarlen;
          burst_d = axiarburst;
          beat_d  = '0;
          err_d   = 1'b0;
          lastw_d = 1'b0;
          state_d = ST_RMEM;
        end
      end

      ST_RMEM: begin
        if (beat_err) begin
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          rlast_d  = is_last;
          rvalid_d = 1'b1;
          state_d  = ST_RDATA;
        end else begin
          memreq_d  = 1'b1;
          memwr_d   = 1'b0;
          memaddr_d = addr_q[MADDRBITS+2:3];
          state_d   = ST_RWAIT;
        end
      end

      ST_RWAIT: begin
        if (memack) begin
          rdata_d  = memrdata;
          rresp_d  = RESP_OKAY;
          rlast_d  = is_last;
          rvalid_d = 1'b1;
          state_d  = ST_RDATA;
        end
      end

      ST_RDATA: begin
        if (axirready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (is_last) begin
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + 4'd1;
            addr_d  = next_addr;
            state_d = ST_RMEM;
          end
        end
      end

      ST_WDATA: begin
        if (axiwvalid) begin
          if (axiwlast != is_last) begin
            err_d = 1'b1;
          end
          if (!is_last) begin
            beat_d = beat_q + 4'd1;
            addr_d = next_addr;
          end
          if (!beat_err) begin
            memreq_d   = 1'b1;
            memwr_d    = 1'b1;
            memaddr_d  = addr_q[MADDRBITS+2:3];
            memwdata_d = axiwdata;
            memwstrb_d = axiwstrb;
            wdone_d    = is_last;
            state_d    = ST_WWAIT;
          end else begin
            err_d = 1'b1;
            if (is_last) begin
              bresp_d  = RESP_SLVERR;
              bvalid_d = 1'b1;
              state_d  = ST_WRESP;
            end
          end
        end
      end

      ST_WWAIT: begin
        if (memack) begin
          if (wdone_q) begin
            bresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
            bvalid_d = 1'b1;
            state_d  = ST_WRESP;
          end else begin
            state_d = ST_WDATA;
          end
        end
      end

      ST_WRESP: begin
        if (axibready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously so every output reads 0 in reset.
  always_ff @(posedge clk or negedge axiaresetn) begin
    if (!axiaresetn) begin
      state_q    <= ST_IDLE;
      lastw_q    <= 1'b0;
      addr_q     <= '0;
      id_q       <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      wdone_q    <= 1'b0;
      memreq_q   <= 1'b0;
      memwr_q    <= 1'b0;
      memaddr_q  <= '0;
      memwdata_q <= '0;
      memwstrb_q <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      bresp_q    <= '0;
      bvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lastw_q    <= lastw_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      wdone_q    <= wdone_d;
      memreq_q   <= memreq_d;
      memwr_q    <= memwr_d;
      memaddr_q  <= memaddr_d;
      memwdata_q <= memwdata_d;
      memwstrb_q <= memwstrb_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      rvalid_q   <= rvalid_d;
      bresp_q    <= bresp_d;
      bvalid_q   <= bvalid_d;
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: stimulus pushes expected memory cycles,
// R beats and B responses; independent monitors pop and compare.
module tb_axi_slave_mem;
  import axi_pkg::*;

  localparam logic [31:0] MEMSIZE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        axiaresetn;
  logic [31:0] axiawaddr;  logic [5:0] axiawid;  logic [3:0] axiawlen;  logic [1:0] axiawburst;
  logic        axiawvalid, axiawready;
  logic [63:0] axiwdata;   logic [7:0] axiwstrb; logic axiwlast, axiwvalid, axiwready;
  logic [5:0]  axibid;     logic [1:0] axibresp; logic axibvalid, axibready;
  logic [31:0] axiaraddr;  logic [5:0] axiarid;  logic [3:0] axiarlen;  logic [1:0] axiarburst;
  logic        axiarvalid, axiarready;
  logic [63:0] axirdata;   logic [5:0] axirid;   logic [1:0] axirresp;
  logic        axirlast, axirvalid, axirready;
  logic        memreq, memwr;
  logic [18:0] memaddr;
  logic [63:0] memwdata;   logic [7:0] memwstrb;
  logic        memack;
  logic [63:0] memrdata;

  logic [178:0] outs;
  assign outs = {axiawready, axiwready, axibid, axibresp, axibvalid, axiarready,
                 axirdata, axirid, axirresp, axirlast, axirvalid,
                 memreq, memwr, memaddr, memwdata, memwstrb};

  axi_slave_mem #(.MEMSIZE(MEMSIZE), .MADDRBITS(19)) dut (
    .clk(clk), .axiaresetn(axiaresetn),
    .axiawaddr(axiawaddr), .axiawid(axiawid), .axiawlen(axiawlen), .axiawburst(axiawburst),
    .axiawvalid(axiawvalid), .axiawready(axiawready),
    .axiwdata(axiwdata), .axiwstrb(axiwstrb), .axiwlast(axiwlast),
    .axiwvalid(axiwvalid), .axiwready(axiwready),
    .axibid(axibid), .axibresp(axibresp), .axibvalid(axibvalid), .axibready(axibready),
    .axiaraddr(axiaraddr), .axiarid(axiarid), .axiarlen(axiarlen), .axiarburst(axiarburst),
    .axiarvalid(axiarvalid), .axiarready(axiarready),
    .axirdata(axirdata), .axirid(axirid), .axirresp(axirresp), .axirlast(axirlast),
    .axirvalid(axirvalid), .axirready(axirready),
    .memreq(memreq), .memwr(memwr), .memaddr(memaddr), .memwdata(memwdata),
    .memwstrb(memwstrb), .memack(memack), .memrdata(memrdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [18:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    int          delay;
    logic [63:0] rdata;
  } mem_t;
  typedef struct { logic [63:0] data; logic [5:0] id; logic [1:0] resp; logic last; } r_t;
  typedef struct { logic [5:0] id; logic [1:0] resp; } b_t;

  mem_t mem_q[$];
  r_t   r_q[$];
  b_t   b_q[$];

  int checks = 0;
  int passed = 0;
  logic busy = 1'b0;
  int stall_beat = -1;
  int stall_cycles = 0;
  int stalled = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic flag(input string name);
    checks++;
    $display("FAIL %s: event not as required", name);
  endtask

  function automatic void push_mr(input logic [18:0] a, input int d, input logic [63:0] rd);
    mem_t m;
    m.wr = 1'b0; m.addr = a; m.wdata = '0; m.strb = '0; m.delay = d; m.rdata = rd;
    mem_q.push_back(m);
  endfunction

  function automatic void push_mw(input logic [18:0] a, input logic [63:0] wd,
                                  input logic [7:0] s, input int d);
    mem_t m;
    m.wr = 1'b1; m.addr = a; m.wdata = wd; m.strb = s; m.delay = d; m.rdata = '0;
    mem_q.push_back(m);
  endfunction

  function automatic void push_r(input logic [63:0] d, input logic [5:0] id,
                                 input logic [1:0] resp, input logic last);
    r_t r;
    r.data = d; r.id = id; r.resp = resp; r.last = last;
    r_q.push_back(r);
  endfunction

  function automatic void push_b(input logic [5:0] id, input logic [1:0] resp);
    b_t b;
    b.id = id; b.resp = resp;
    b_q.push_back(b);
  endfunction

  // Memory responder: compares each request and acks after the queued delay.
  initial begin
    mem_t e;
    int d;
    memack = 1'b0;
    memrdata = '0;
    forever begin
      @(negedge clk);
      if (memreq) begin
        busy = 1'b1;
        if (mem_q.size() == 0) begin
          flag("mem_unexpected");
          d = 1;
          e.rdata = '0;
        end else begin
          e = mem_q.pop_front();
          chk("mem_wr", memwr, e.wr);
          chk("mem_addr", memaddr, e.addr);
          if (e.wr) begin
            chk("mem_wdata", memwdata, e.wdata);
            chk("mem_wstrb", memwstrb, e.strb);
          end
          d = e.delay;
        end
        repeat (d) begin
          @(posedge clk); #1;
          chk("memreq_single_outstanding", memreq, 1'b0);
        end
        memrdata = e.rdata;
        memack = 1'b1;
        @(posedge clk); #1;
        memack = 1'b0;
        memrdata = '0;
        busy = 1'b0;
      end
    end
  end

  // R monitor: drives rready (with optional stall) and compares each accepted beat.
  initial begin
    r_t r;
    logic [63:0] held;
    int r_beat;
    r_beat = 0;
    held = '0;
    axirready = 1'b1;
    forever begin
      @(negedge clk);
      if (axirvalid) begin
        if (r_beat == stall_beat && stalled < stall_cycles) begin
          if (stalled == 0) held = axirdata;
          else chk("rdata_hold", axirdata, held);
          stalled++;
          axirready = 1'b0;
        end else begin
          axirready = 1'b1;
          if (r_q.size() == 0) flag("r_unexpected");
          else begin
            r = r_q.pop_front();
            chk("r_beat", {axirdata, axirid, axirresp, axirlast}, {r.data, r.id, r.resp, r.last});
          end
          r_beat = axirlast ? 0 : r_beat + 1;
        end
      end else begin
        axirready = 1'b1;
      end
    end
  end

  // B monitor: bready is held high; compare every response.
  initial begin
    b_t b;
    axibready = 1'b1;
    forever begin
      @(negedge clk);
      if (axibvalid) begin
        if (b_q.size() == 0) flag("b_unexpected");
        else begin
          b = b_q.pop_front();
          chk("b_resp", {axibid, axibresp}, {b.id, b.resp});
        end
      end
    end
  end

  task automatic do_aw(input logic [31:0] a, input logic [5:0] id, input logic [3:0] len,
                       input logic [1:0] burst);
    int n;
    @(posedge clk); #1;
    axiawaddr = a; axiawid = id; axiawlen = len; axiawburst = burst; axiawvalid = 1'b1;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (axiawready) break;
    end
    if (n >= 500) flag("aw_timeout");
    @(posedge clk); #1;
    axiawvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [5:0] id, input logic [3:0] len,
                       input logic [1:0] burst);
    int n;
    @(posedge clk); #1;
    axiaraddr = a; axiarid = id; axiarlen = len; axiarburst = burst; axiarvalid = 1'b1;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (axiarready) break;
    end
    if (n >= 500) flag("ar_timeout");
    @(posedge clk); #1;
    axiarvalid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] d, input logic [7:0] s, input logic last);
    int n;
    @(posedge clk); #1;
    axiwdata = d; axiwstrb = s; axiwlast = last; axiwvalid = 1'b1;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (axiwready) break;
    end
    if (n >= 500) flag("w_timeout");
    @(posedge clk); #1;
    axiwvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((mem_q.size() != 0 || r_q.size() != 0 || b_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) flag({name, "_timeout"});
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    axiaresetn = 1'b0;
    axiawaddr = '0; axiawid = '0; axiawlen = '0; axiawburst = '0; axiawvalid = 1'b1;
    axiwdata = '0; axiwstrb = '0; axiwlast = 1'b0; axiwvalid = 1'b0;
    axiaraddr = '0; axiarid = '0; axiarlen = '0; axiarburst = '0; axiarvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs, '0);
    axiawvalid = 1'b0;
    axiarvalid = 1'b0;
    @(posedge clk); #1;
    axiaresetn = 1'b1;

    // Both valid after reset: write, read, write.
    push_mw(19'h40, 64'h1111_2222_3333_4444, 8'h0F, 1);
    push_mr(19'h60, 2, 64'hA5A5_5A5A_0F0F_F0F0);
    push_mw(19'h41, 64'h5555_6666_7777_8888, 8'hF0, 1);
    push_b(6'd1, RESP_OKAY);
    push_r(64'hA5A5_5A5A_0F0F_F0F0, 6'd3, RESP_OKAY, 1'b1);
    push_b(6'd4, RESP_OKAY);
    fork
      begin
        do_aw(32'h200, 6'd1, 4'd0, BURST_INCR);
        do_w(64'h1111_2222_3333_4444, 8'h0F, 1'b1);
        do_aw(32'h208, 6'd4, 4'd0, BURST_INCR);
        do_w(64'h5555_6666_7777_8888, 8'hF0, 1'b1);
      end
      do_ar(32'h300, 6'd3, 4'd0, BURST_INCR);
    join
    drain("arbitration");

    // Single read.
    push_mr(19'h20, 3, 64'hDEAD_BEEF_0123_4567);
    push_r(64'hDEAD_BEEF_0123_4567, 6'd5, RESP_OKAY, 1'b1);
    do_ar(32'h100, 6'd5, 4'd0, BURST_INCR);
    drain("single_read");

    // INCR write burst with varying memory latency.
    push_mw(19'd8,  64'h0101_0101_0101_0101, 8'hFF, 1);
    push_mw(19'd9,  64'h0202_0202_0202_0202, 8'hFF, 2);
    push_mw(19'd10, 64'h0303_0303_0303_0303, 8'hFF, 1);
    push_mw(19'd11, 64'h0404_0404_0404_0404, 8'hFF, 4);
    push_b(6'd2, RESP_OKAY);
    do_aw(32'h40, 6'd2, 4'd3, BURST_INCR);
    do_w(64'h0101_0101_0101_0101, 8'hFF, 1'b0);
    do_w(64'h0202_0202_0202_0202, 8'hFF, 1'b0);
    do_w(64'h0303_0303_0303_0303, 8'hFF, 1'b0);
    do_w(64'h0404_0404_0404_0404, 8'hFF, 1'b1);
    drain("incr_write");

    // FIXED read burst, rready stalled on beat 1.
    stall_beat = 1; stall_cycles = 5; stalled = 0;
    push_mr(19'd3, 1, 64'h0000_0000_AAAA_0000);
    push_mr(19'd3, 1, 64'h0000_0000_BBBB_0001);
    push_mr(19'd3, 1, 64'h0000_0000_CCCC_0002);
    push_r(64'h0000_0000_AAAA_0000, 6'd7, RESP_OKAY, 1'b0);
    push_r(64'h0000_0000_BBBB_0001, 6'd7, RESP_OKAY, 1'b0);
    push_r(64'h0000_0000_CCCC_0002, 6'd7, RESP_OKAY, 1'b1);
    do_ar(32'h18, 6'd7, 4'd2, BURST_FIXED);
    drain("fixed_read");
    chk("stall_applied", stalled, 5);
    stall_beat = -1;

    // Out-of-window read: no memory cycles, two SLVERR beats.
    push_r(64'h0, 6'd9, RESP_SLVERR, 1'b0);
    push_r(64'h0, 6'd9, RESP_SLVERR, 1'b1);
    do_ar(MEMSIZE, 6'd9, 4'd1, BURST_INCR);
    drain("oor_read");

    // Write straddling the window end: first beat hits memory, second errors.
    push_mw(19'h7FFFF, 64'hFEED_0000_0000_0001, 8'hFF, 1);
    push_b(6'd10, RESP_SLVERR);
    do_aw(MEMSIZE - 32'd8, 6'd10, 4'd1, BURST_INCR);
    do_w(64'hFEED_0000_0000_0001, 8'hFF, 1'b0);
    do_w(64'hFEED_0000_0000_0002, 8'hFF, 1'b1);
    drain("oor_write");

    // Early wlast on beat 0: both beats still written, response is SLVERR.
    push_mw(19'h10, 64'h0BAD_0000_0000_0000, 8'h3C, 1);
    push_mw(19'h11, 64'h0BAD_0000_0000_0001, 8'hC3, 1);
    push_b(6'd11, RESP_SLVERR);
    do_aw(32'h80, 6'd11, 4'd1, BURST_INCR);
    do_w(64'h0BAD_0000_0000_0000, 8'h3C, 1'b1);
    do_w(64'h0BAD_0000_0000_0001, 8'hC3, 1'b1);
    drain("wlast_mismatch");

    // Reset during RWAIT, stale memack lands in IDLE, then a fresh read.
    push_mr(19'h80, 6, 64'h1234_5678_9ABC_DEF0);
    do_ar(32'h400, 6'd12, 4'd0, BURST_INCR);
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (memreq) break;
    end
    if (n >= 50) flag("reset_test_memreq_timeout");
    #1 axiaresetn = 1'b0;
    #1 chk("midreset_outputs", outs, '0);
    repeat (2) @(posedge clk);
    #1 axiaresetn = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) flag("stale_ack_timeout");
    repeat (2) @(negedge clk);
    push_mr(19'h81, 2, 64'hCAFE_F00D_0000_0081);
    push_r(64'hCAFE_F00D_0000_0081, 6'd13, RESP_OKAY, 1'b1);
    do_ar(32'h408, 6'd13, 4'd0, BURST_INCR);
    drain("after_reset");

    chk("queues_empty", mem_q.size() + r_q.size() + b_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
